gaussian_cascade_stage: RTL

Parametrised Gaussian smoothing stage between the down sampler and the up sampler in the scale-space pipeline. It runs NUM_PASSES cascaded 3-tap [1 2 1]/4 passes on accepted pixels and discards the pipeline-fill outputs at reset and at every line start. Results are buffered in an internal FIFO with real backpressure to the upstream source. A bypass mode forwards raw pixels.

---
 rtl/gaussian_pkg.sv | 28 ++
 rtl/gaussian_pass.sv | 46 ++++
 rtl/gaussian_cascade_stage.sv | 112 +++++++++++
 3 files changed

// File: rtl/gaussian_pkg.sv
// Shared constants for the Gaussian cascade stage: fill depth, [1 2 1]/4 kernel
// weights with rounding, and a constant-width helper for FIFO pointers.
package gaussian_pkg;

  localparam int FILL_PER_PASS = 2;

  localparam int W_NEW  = 1;
  localparam int W_PREV = 2;
  localparam int W_OLD  = 1;
  localparam int ROUND  = 2;
  localparam int SHIFT  = 2;

  typedef enum logic [1:0] {
    WR_NONE,
    WR_FILTER,
    WR_BYPASS
  } wr_src_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/gaussian_pass.sv
// One 3-tap [1 2 1]/4 smoothing pass. The output is combinational from x; the
// two-sample window advances only on accepted filter samples and restarts on sol.
module gaussian_pass
  import gaussian_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  logic              clear,
  input  logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] y
);

  localparam int SUM_W = DATA_W + 2;

  logic [DATA_W-1:0] r_w0;
  logic [DATA_W-1:0] r_w1;
  logic [DATA_W-1:0] w_w0;
  logic [DATA_W-1:0] w_w1;
  logic [SUM_W-1:0]  w_sum;

  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    w_w0  = clear ? '0 : r_w0;
    w_w1  = clear ? '0 : r_w1;
    w_sum = SUM_W'(W_NEW)  * {2'b00, x}
          + SUM_W'(W_PREV) * {2'b00, w_w0}
          + SUM_W'(W_OLD)  * {2'b00, w_w1}
          + SUM_W'(ROUND);
    y     = DATA_W'(w_sum >> SHIFT);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_w0 <= '0;
      r_w1 <= '0;
    end else if (advance) begin
      r_w0 <= x;
      r_w1 <= w_w0;
    end
  end

endmodule

// File: rtl/gaussian_cascade_stage.sv
// Cascaded Gaussian smoothing stage: NUM_PASSES 3-tap passes with fill discard at
// reset and line start, a bypass path, and an output FIFO with upstream backpressure.
module gaussian_cascade_stage
  import gaussian_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_PASSES = 2,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [DATA_W-1:0] din,
  input  logic              sol,
  input  logic              bypass,
  output logic              rd_en_down,
  input  logic              rd_en_up,
  output logic [DATA_W-1:0] dout,
  output logic              valid_out,
  output logic              empty,
  output logic              full
);

  localparam int FILL  = FILL_PER_PASS * NUM_PASSES;
  localparam int FC_W  = clog2(FILL + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [FC_W-1:0]   r_fc;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic [DATA_W-1:0] w_stage [NUM_PASSES+1];
  logic              w_accept;
  logic              w_filt_acc;
  wr_src_e           w_wr_src;
  logic              w_wr_en;
  logic              w_rd_en;
  logic [DATA_W-1:0] w_wr_data;

  assign rd_en_down = !rst && (r_count < CNT_W'(FIFO_DEPTH));
  assign empty      = (r_count == '0);
  assign full       = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_accept   = valid && rd_en_down;
  assign w_filt_acc = w_accept && !bypass;
  assign w_rd_en    = rd_en_up && !empty;
  assign w_stage[0] = din;

  genvar g;
  for (g = 0; g < NUM_PASSES; g++) begin : g_pass
    gaussian_pass #(
      .DATA_W (DATA_W)
    ) u_pass (
      .clk     (clk),
      .rst     (rst),
      .advance (w_filt_acc),
      .clear   (sol),
      .x       (w_stage[g]),
      .y       (w_stage[g+1])
    );
  end

  // A filtered sample is written only once every pass window holds real line data.
  always_comb begin
    w_wr_src = WR_NONE;
    if (w_accept) begin
      if (bypass)                           w_wr_src = WR_BYPASS;
      else if (!sol && r_fc == FC_W'(FILL)) w_wr_src = WR_FILTER;
    end
    w_wr_en   = (w_wr_src != WR_NONE);
    w_wr_data = (w_wr_src == WR_BYPASS) ? din : w_stage[NUM_PASSES];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fc <= '0;
    end else if (w_filt_acc) begin
      if (sol)                     r_fc <= FC_W'(1);
      else if (r_fc != FC_W'(FILL)) r_fc <= r_fc + FC_W'(1);
    end
  end

  // NOTE: the storage array has no reset; count and pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= w_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      dout      <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= w_rd_en;
      if (w_rd_en) begin
        dout     <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule
